stoch_window_counter: RTL

Downstream consumer of the burst gate and other stochastic-bitstream operators. It converts a unipolar stochastic bitstream into a binary magnitude by counting ones over a fixed window of 2^WIDTH enabled samples. It publishes the result with a one-cycle VALID strobe. Supports single-shot and continuous (back-to-back window) operation, and feeds binary readout and debug logic at the network output.

---
 rtl/stoch_window_counter_pkg.sv | 15 +
 rtl/stoch_window_counter.sv | 95 +++++++++
 2 files changed

// File: rtl/stoch_window_counter_pkg.sv
// Shared definitions for the stochastic-bitstream operators.
//   state_t       : window-counter FSM state encoding (idle / accumulating)
//   window_len()  : number of enabled samples in one window for a given width
package stoch_window_counter_pkg;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_ACC  = 1'b1
  } state_t;

  function automatic int unsigned window_len(input int unsigned width);
    return 32'd1 << width;
  endfunction

endpackage

// File: rtl/stoch_window_counter.sv
// Converts a unipolar stochastic bitstream into a binary magnitude by counting
// ones over a window of 2^WIDTH enabled samples.
//
// Ports:
//   CLK   : system clock, all state changes on the rising edge
//   INIT  : synchronous active-high reset, overrides every other input
//   START : single-cycle pulse that begins or restarts a window
//   CONT  : 1 = back-to-back windows, 0 = one window then idle (sampled at window end)
//   EN    : sample qualifier; IN is counted only when EN=1
//   IN    : stochastic bitstream input
//   OUT   : last completed window count, saturated to 2^WIDTH-1
//   VALID : one-cycle strobe, OUT/SAT were updated on the preceding edge
//   SAT   : last completed window was all ones (count reached 2^WIDTH)
//   BUSY  : a window is in progress
module stoch_window_counter
  import stoch_window_counter_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic             CLK,
  input  logic             INIT,
  input  logic             START,
  input  logic             CONT,
  input  logic             EN,
  input  logic             IN,
  output logic [WIDTH-1:0] OUT,
  output logic             VALID,
  output logic             SAT,
  output logic             BUSY
);

  localparam int unsigned WIN = window_len(WIDTH);

  state_t           state;
  logic [WIDTH:0]   acc;
  logic [WIDTH-1:0] scnt;
  logic [WIDTH:0]   acc_next;
  logic             last_sample;

  always_comb begin
    acc_next    = acc + {{WIDTH{1'b0}}, IN};
    last_sample = EN && (32'(scnt) == WIN - 1);
  end

  // Window end takes precedence over START so a coincident START still lets
  // the finishing window publish; START then only forces the next window on.
  always_ff @(posedge CLK) begin
    if (INIT) begin
      state <= ST_IDLE;
      acc   <= '0;
      scnt  <= '0;
      OUT   <= '0;
      VALID <= 1'b0;
      SAT   <= 1'b0;
      BUSY  <= 1'b0;
    end else begin
      VALID <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (START) begin
            state <= ST_ACC;
            acc   <= '0;
            scnt  <= '0;
            BUSY  <= 1'b1;
          end
        end
        ST_ACC: begin
          if (last_sample) begin
            // acc_next[WIDTH] set means every sample was a one (count = 2^WIDTH)
            OUT   <= acc_next[WIDTH] ? '1 : acc_next[WIDTH-1:0];
            SAT   <= acc_next[WIDTH];
            VALID <= 1'b1;
            acc   <= '0;
            scnt  <= '0;
            if (!(CONT || START)) begin
              state <= ST_IDLE;
              BUSY  <= 1'b0;
            end
          end else if (START) begin
            acc  <= '0;
            scnt <= '0;
          end else if (EN) begin
            acc  <= acc_next;
            scnt <= scnt + 1'b1;
          end
        end
        default: begin
          state <= ST_IDLE;
          BUSY  <= 1'b0;
        end
      endcase
    end
  end

endmodule
